// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and a parity helper.
// The transmitter and receiver both import this package.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Parity over the low data_bits of data; odd mode inverts the XOR reduction.
    function automatic logic parity_bit(input logic [7:0] data, input int data_bits,
                                        input int parity);
        logic ones;
        ones = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < data_bits) ones = ones ^ data[i];
        end
        return (parity == PARITY_ODD) ? ~ones : ones;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous input FIFO for the UART transmitter.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// Serialising UART transmitter: FIFO-buffered byte input, configurable frame format.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a FIFO entry
//   ST_START  | start bit (low)
//   ST_DATA   | payload bits, LSB first
//   ST_PARITY | parity bit (only when PARITY != none)
//   ST_STOP   | STOP_BITS stop bits (high); pops the next byte at the end
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t       state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              par_q;
    logic              tx_q;
    logic              tx_next;
    logic              baud_wrap;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // Popping at the last stop-bit wrap chains frames with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) ||
                       ((state == ST_STOP) && baud_wrap && (bit_cnt == STOP_LAST)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_q <= tx_next;
            if (fifo_pop) begin
                state    <= ST_START;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= fifo_dout;
                par_q    <= parity_bit(fifo_dout, DATA_BITS, PARITY);
            end else if (state != ST_IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                if (baud_wrap) begin
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                        ST_DATA: begin
                            shift <= shift >> 1;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        ST_PARITY: state <= ST_STOP;
                        ST_STOP: begin
                            if (bit_cnt == STOP_LAST) state <= ST_IDLE;
                            else bit_cnt <= bit_cnt + 3'd1;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one clock.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift[0];
            ST_PARITY: tx_next = par_q;
            default:   tx_next = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three differently configured transmitters, randomized traffic,
// scoreboard of accepted bytes checked against the serial line, busy and tx_ready.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam longint LIMIT = 80000;

    typedef struct {
        logic [7:0] d;
        int         gap;
    } stim_t;

    typedef struct {
        logic [7:0] d;
        longint     acc;
        longint     st;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    longint     cyc = 0;
    logic [2:0] vld = '0;
    logic [7:0] dat [3];
    logic [2:0] rdy;
    logic [2:0] txl;
    logic [2:0] bsy;

    stim_t  stim [3][$];
    item_t  sbq  [3][$];
    longint last_st [3];
    int     gap_left [3];
    bit [2:0] took = '0;
    int     drain_to = 0;
    bit     done = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));

    uart_tx #(.CLKS_PER_BIT(7), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));

    function automatic int cpb(input int k);
        case (k) 0: return 104; 1: return 7; default: return 4; endcase
    endfunction
    function automatic int dbits(input int k);
        case (k) 0: return 8; 1: return 8; default: return 5; endcase
    endfunction
    function automatic int pmode(input int k);
        case (k) 0: return 0; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int sbits(input int k);
        case (k) 0: return 1; 1: return 2; default: return 1; endcase
    endfunction
    function automatic int depth(input int k);
        case (k) 0: return 4; 1: return 4; default: return 2; endcase
    endfunction
    function automatic int flen(input int k);
        return (1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k)) * cpb(k);
    endfunction

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int idx);
        int ones;
        ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= dbits(k)) return d[idx-1];
        if (pmode(k) != 0 && idx == dbits(k) + 1) begin
            for (int i = 0; i < dbits(k); i++) ones += int'(d[i]);
            if (pmode(k) == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    function automatic bit stim_left();
        return (stim[0].size() + stim[1].size() + stim[2].size()) != 0;
    endfunction

    task automatic add_stim(input int k, input logic [7:0] d, input int gap);
        stim_t s;
        s.d   = d;
        s.gap = gap;
        stim[k].push_back(s);
    endtask

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One negedge worth of handshake driving for every DUT.
    task automatic drive_cycle();
        item_t it;
        longint chain;
        for (int k = 0; k < 3; k++) begin
            if (took[k]) begin
                took[k] = 1'b0;
                vld[k]  = 1'b0;
            end
            if (!vld[k]) begin
                if (stim[k].size() > 0) begin
                    if (gap_left[k] < 0) gap_left[k] = stim[k][0].gap;
                    if (gap_left[k] > 0) gap_left[k]--;
                    else begin
                        dat[k] = stim[k][0].d;
                        vld[k] = 1'b1;
                        gap_left[k] = -1;
                    end
                end
            end else begin
                dat[k] = 8'($urandom);
            end
            if (vld[k] && rdy[k]) begin
                it.d   = dat[k];
                it.acc = cyc + 1;
                chain  = last_st[k] + flen(k);
                it.st  = (it.acc + 2 > chain) ? it.acc + 2 : chain;
                last_st[k] = it.st;
                sbq[k].push_back(it);
                took[k] = 1'b1;
                stim[k].delete(0);
            end
        end
    endtask

    task automatic run_until_idle(input longint budget);
        longint t0;
        t0 = cyc;
        while ((stim_left() || vld != 3'b000 || bsy != 3'b000) && cyc < t0 + budget) begin
            @(negedge clk);
            drive_cycle();
        end
        if (cyc >= t0 + budget) drain_to++;
        repeat (4) @(negedge clk);
    endtask

    initial begin : driver
        longint target;
        int     g;
        for (int k = 0; k < 3; k++) begin
            dat[k]      = 8'h00;
            gap_left[k] = -1;
            last_st[k]  = -100000;
        end
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;

        add_stim(0, 8'h31, 3);
        add_stim(0, 8'h55, 1100);
        add_stim(0, 8'hA3, 0);
        add_stim(0, 8'hC4, 2300);
        add_stim(0, 8'h19, 0);
        add_stim(0, 8'h7E, 0);
        add_stim(0, 8'h80, 0);
        add_stim(0, 8'h3D, 0);
        add_stim(0, 8'hE2, 0);
        for (int n = 0; n < 10; n++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, flen(0))) : 0;
            add_stim(0, 8'($urandom), g);
        end
        for (int n = 0; n < 60; n++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, flen(1))) : 0;
            add_stim(1, 8'($urandom), g);
        end
        for (int n = 0; n < 100; n++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, flen(2))) : 0;
            add_stim(2, 8'($urandom), g);
        end
        run_until_idle(50000);

        // Abort a frame in data bit 3 (a zero bit of 0xF0) with two more bytes queued.
        add_stim(0, 8'hF0, 2);
        add_stim(0, 8'h12, 0);
        add_stim(0, 8'h34, 0);
        target = cyc + 100;
        while (stim[0].size() == 3 && cyc < target) begin
            @(negedge clk);
            drive_cycle();
        end
        if (stim[0].size() == 3) drain_to++;
        target = last_st[0] + 4 * cpb(0) + cpb(0) / 2;
        while (cyc < target) begin
            @(negedge clk);
            drive_cycle();
        end
        @(posedge clk);
        #2 rst = 1'b0;
        vld  = '0;
        took = '0;
        for (int k = 0; k < 3; k++) begin
            stim[k].delete();
            gap_left[k] = -1;
            last_st[k]  = -100000;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        for (int k = 0; k < 3; k++) add_stim(k, 8'h0F, 3);
        run_until_idle(20000);
        done = 1'b1;
    end

    initial begin : monitor
        item_t  cur [3];
        bit     inf [3];
        longint fs [3];
        int     t [3];
        int     nbad [3];
        int     first_bad [3];
        int     occ;
        bit     pend;
        bit     exp_busy;
        bit     exp_ready;
        for (int k = 0; k < 3; k++) inf[k] = 1'b0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 3; k++) begin
                    check(txl[k] == 1'b1, $sformatf("reset_tx[%0d]", k), txl[k], 1);
                    check(bsy[k] == 1'b0, $sformatf("reset_busy[%0d]", k), bsy[k], 0);
                    check(rdy[k] == 1'b1, $sformatf("reset_ready[%0d]", k), rdy[k], 1);
                    inf[k] = 1'b0;
                    sbq[k].delete();
                end
                continue;
            end
            for (int k = 0; k < 3; k++) begin
                if (!inf[k]) begin
                    if (txl[k] == 1'b0) begin
                        check(sbq[k].size() > 0, $sformatf("unexpected_start[%0d]", k),
                              sbq[k].size(), 1);
                        if (sbq[k].size() > 0) begin
                            cur[k] = sbq[k].pop_front();
                            check(cyc == cur[k].st, $sformatf("start_time[%0d]", k),
                                  cyc, cur[k].st);
                            inf[k]  = 1'b1;
                            fs[k]   = cyc;
                            t[k]    = 0;
                            nbad[k] = 0;
                        end
                    end
                end else begin
                    t[k]++;
                end
                if (inf[k]) begin
                    if (txl[k] !== exp_bit(k, cur[k].d, t[k] / cpb(k))) begin
                        if (nbad[k] == 0) first_bad[k] = t[k];
                        nbad[k]++;
                    end
                    if (t[k] == flen(k) - 1) begin
                        check(nbad[k] == 0,
                              $sformatf("frame_bits[%0d] byte 0x%02h first bad offset", k, cur[k].d),
                              (nbad[k] == 0) ? -1 : first_bad[k], -1);
                        inf[k] = 1'b0;
                    end
                end
                occ  = 0;
                pend = 1'b0;
                for (int i = 0; i < sbq[k].size(); i++) begin
                    if (sbq[k][i].acc <= cyc) begin
                        pend = 1'b1;
                        if (sbq[k][i].st - 1 > cyc) occ++;
                    end
                end
                exp_busy  = pend || (inf[k] && cyc < fs[k] + flen(k) - 1);
                exp_ready = occ < depth(k);
                check(bsy[k] == exp_busy, $sformatf("busy[%0d]", k), bsy[k], exp_busy);
                check(rdy[k] == exp_ready, $sformatf("tx_ready[%0d]", k), rdy[k], exp_ready);
            end
        end
        check(cyc < LIMIT, "watchdog", cyc, LIMIT);
        check(drain_to == 0, "drain_timeout", drain_to, 0);
        for (int k = 0; k < 3; k++)
            check(sbq[k].size() == 0, $sformatf("leftover[%0d]", k), sbq[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
